dsp_sample_capture: RTL and testbench
=====================================

Name: dsp_sample_capture

Overview:
- Capture buffer directly downstream of the decimating downsampler filters.
- Consumes the decimated 16-bit X/Y sample pair on each `ce_out` strobe and stores a triggered burst of pairs in on-chip RAM.
- The SoC CPU reads the stored burst back through a simple synchronous read port, for baseband inspection without a logic analyser.

Parameters:
- DW, 16, width of each of the X and Y samples (signed).
- AW, 10, RAM address width; DEPTH = 2^AW sample pairs.

Ports:
- sys_clk  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample strobe (downsampler `ce_out`); one cycle per decimated sample.
- in_x  input  DW  signed X sample; valid when in_valid=1.
- in_y  input  DW  signed Y sample; valid when in_valid=1.
- arm  input  1  single-cycle pulse; starts a capture.
- abort  input  1  single-cycle pulse; returns to IDLE.
- trig_mode  input  1  0 = immediate start; 1 = X rising threshold crossing.
- trig_level  input  DW  signed threshold used when trig_mode=1.
- cap_len  input  AW+1  pairs to capture; 0 or any value > DEPTH means DEPTH.
- rd_en  input  1  read request.
- rd_addr  input  AW  read address.
- rd_data  output  2*DW  {x,y} read result (x in the upper half).
- rd_valid  output  1  rd_data is valid.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  high in DONE.
- wr_count  output  AW+1  pairs written in the current or last capture.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, wr_count=0, rd_valid=0, rd_data=0, prev_x=0. RAM contents are not reset.
- States: IDLE, ARMED, CAPTURE, DONE.
- arm is accepted only in IDLE or DONE. On acceptance:
  - latch trig_mode, trig_level and the effective length (len_q);
  - clear wr_count;
  - go to ARMED.
- arm is ignored in ARMED and CAPTURE.
- ARMED, trig_mode=0: the first in_valid sample is written to address 0 in that same cycle; state goes to CAPTURE.
- ARMED, trig_mode=1:
  - trigger on an in_valid sample where prev_x < trig_level and in_x >= trig_level (signed compare);
  - the triggering sample is written to address 0;
  - prev_x updates on every in_valid in all states;
  - a crossing requires a prior sample, so the first sample after arm can trigger only against the prev_x held from before arm.
- CAPTURE: each in_valid writes {in_x,in_y} at address wr_count, then wr_count increments. When the increment reaches len_q, go to DONE next cycle.
- len_q=1: the trigger sample completes the capture; go ARMED -> DONE directly.
- DONE: holds until arm or abort. Further in_valid strobes are not written.
- abort, any state: go to IDLE next cycle. wr_count keeps its value and RAM keeps its data.
- abort and arm in the same cycle: abort wins.
- in_valid together with the arm-accept cycle: the sample is not captured, but it does update prev_x.
- No wrap-around: the write address never exceeds len_q-1, which is at most DEPTH-1.
- Read port:
  - rd_en registered; rd_data/rd_valid appear exactly 1 cycle after rd_en;
  - rd_valid=0 otherwise, and rd_data holds its last value;
  - reads are legal in any state;
  - a read and a write to the same address in the same cycle return the old data (read-first).
- Throughput: accepts in_valid every cycle (no back-pressure). in_valid spacing in the system is the decimation ratio.

Decomposition:
- Package dsp_capture_pkg holds:
  - state encoding constants (IDLE=0, ARMED=1, CAPTURE=2, DONE=3);
  - trigger-mode constants (TRIG_IMM=0, TRIG_RISE=1);
  - a helper for effective length (0 or >DEPTH -> DEPTH).
- One sub-module, capture_ram: simple dual-port RAM, width 2*DW, depth 2^AW, one write port, registered read-first read port, inferable as block RAM.

Test Plan:
- Immediate capture, cap_len=4:
  - arm, then in_valid every 8 cycles with x=1..4, y=-1..-4;
  - done=1 after the 4th strobe, wr_count=4;
  - reading addrs 0..3 gives {0x0001,0xFFFF}..{0x0004,0xFFFC}, each 1 cycle after rd_en.
- Threshold trigger:
  - trig_mode=1, trig_level=100; x sequence 50, 99, 100, 150, 120 with cap_len=3;
  - capture starts at x=100; RAM[0..2] holds x=100, 150, 120;
  - x=100 followed by a later 100 (no rise) must not trigger.
- Negative threshold: trig_level=-10, x going -20 -> -10 triggers (signed compare); x going 5 -> -10 does not.
- cap_len=0 fills all 1024 pairs (wr_count=1024, done=1); 1030 strobes are sent, and RAM[0] is not overwritten by strobes 1025+.
- Abort mid-capture, cap_len=8:
  - abort after 3 samples -> IDLE, busy=0, done=0, wr_count=3;
  - arm and abort in the same cycle -> stays IDLE;
  - arm during CAPTURE has no effect on wr_count.
- Reset mid-capture: rst_n low for 1 cycle -> all outputs 0 immediately (async); after release, state=IDLE and a new arm works normally.

Source files
------------

// File: rtl/dsp_capture_pkg.sv
// Shared types and helpers for the decimated-sample capture buffer.
package dsp_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam logic TRIG_IMM  = 1'b0;
  localparam logic TRIG_RISE = 1'b1;

  // A zero or oversized request means "fill the whole RAM".
  function automatic logic [31:0] eff_len(input logic [31:0] req_len, input logic [31:0] depth);
    logic [31:0] len_s;
    if ((req_len == 32'd0) || (req_len > depth)) begin
      len_s = depth;
    end else begin
      len_s = req_len;
    end
    return len_s;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, registered read-first read port.
module capture_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(2**AW)-1];
  logic [DW-1:0] rdata_r;

  // Write and read share one edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dsp_sample_capture.sv
// Triggered burst capture of decimated X/Y sample pairs with a CPU read-back port.
module dsp_sample_capture
  import dsp_capture_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_x,
  input  logic [DW-1:0]   in_y,
  input  logic            arm,
  input  logic            abort,
  input  logic            trig_mode,
  input  logic [DW-1:0]   trig_level,
  input  logic [AW:0]     cap_len,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data,
  output logic            rd_valid,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     wr_count
);

  localparam int DEPTH = 2**AW;

  cap_state_t            state_r;
  cap_state_t            next_state_s;
  logic                  mode_r;
  logic signed [DW-1:0]  level_r;
  logic signed [DW-1:0]  prev_x_r;
  logic [AW:0]           len_r;
  logic [AW:0]           wr_count_r;
  logic [AW:0]           next_count_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  rd_valid_r;
  logic                  rd_seen_r;
  logic                  arm_ok_s;
  logic                  cross_s;
  logic                  trig_hit_s;
  logic                  we_s;
  logic [2*DW-1:0]       ram_q_s;

  assign arm_ok_s   = arm && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign cross_s    = (prev_x_r < level_r) && ($signed(in_x) >= level_r);
  assign trig_hit_s = (mode_r == TRIG_IMM) || ((mode_r == TRIG_RISE) && cross_s);

  // Next-state, write-enable and write-count decisions; abort outranks arm.
  always_comb begin
    next_state_s = state_r;
    next_count_s = wr_count_r;
    we_s         = 1'b0;
    if (abort) begin
      next_state_s = ST_IDLE;
    end else if (arm_ok_s) begin
      next_state_s = ST_ARMED;
      next_count_s = {(AW+1){1'b0}};
    end else if (in_valid) begin
      case (state_r)
        ST_ARMED: begin
          if (trig_hit_s) begin
            we_s         = 1'b1;
            next_count_s = {{AW{1'b0}}, 1'b1};
            if (len_r == {{AW{1'b0}}, 1'b1}) begin
              next_state_s = ST_DONE;
            end else begin
              next_state_s = ST_CAPTURE;
            end
          end else begin
            next_state_s = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          we_s         = 1'b1;
          next_count_s = wr_count_r + {{AW{1'b0}}, 1'b1};
          if (next_count_s == len_r) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_CAPTURE;
          end
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Control registers and registered status outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wr_count_r <= {(AW+1){1'b0}};
      mode_r     <= TRIG_IMM;
      level_r    <= {DW{1'b0}};
      len_r      <= {(AW+1){1'b0}};
      prev_x_r   <= {DW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_seen_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wr_count_r <= next_count_s;
      busy_r     <= (next_state_s == ST_ARMED) || (next_state_s == ST_CAPTURE);
      done_r     <= (next_state_s == ST_DONE);
      rd_valid_r <= rd_en;
      if (arm_ok_s) begin
        mode_r  <= trig_mode;
        level_r <= $signed(trig_level);
        len_r   <= (AW+1)'(eff_len(32'(cap_len), 32'(DEPTH)));
      end
      if (in_valid) begin
        prev_x_r <= $signed(in_x);
      end
      if (rd_en) begin
        rd_seen_r <= 1'b1;
      end
    end
  end

  capture_ram #(
    .DW (2*DW),
    .AW (AW)
  ) u_ram (
    .clk   (sys_clk),
    .we    (we_s),
    .waddr (wr_count_r[AW-1:0]),
    .wdata ({in_x, in_y}),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_q_s)
  );

  // The RAM read register has no reset, so it is masked until the first read.
  assign rd_data  = rd_seen_r ? ram_q_s : {(2*DW){1'b0}};
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_dsp_sample_capture.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_dsp_sample_capture;

  localparam int DEPTH = 1024;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_x = 16'd0;
  logic [15:0] in_y = 16'd0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig_mode = 1'b0;
  logic [15:0] trig_level = 16'd0;
  logic [10:0] cap_len = 11'd0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = 10'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [10:0] wr_count;

  always #5 sys_clk = ~sys_clk;

  dsp_sample_capture #(.DW(16), .AW(10)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .arm        (arm),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .cap_len    (cap_len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 armed, 2 capture, 3 done
  int          m_state, m_mode, m_level, m_len, m_cnt, m_prev;
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  bit          m_rv;
  logic [31:0] m_rd;

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic m_reset();
    m_state = 0; m_cnt = 0; m_prev = 0; m_rv = 1'b0; m_rd = 32'd0;
  endtask

  task automatic m_put(input int a);
    m_mem[a] = {in_x, in_y};
    m_wr[a]  = 1'b1;
  endtask

  task automatic model_step();
    bit hit;
    if (rd_en) begin
      m_rd = m_mem[rd_addr];
      m_rv = 1'b1;
    end else begin
      m_rv = 1'b0;
    end
    if (abort) begin
      m_state = 0;
    end else if (arm && (m_state == 0 || m_state == 3)) begin
      m_mode  = int'(trig_mode);
      m_level = sx(trig_level);
      m_len   = (cap_len == 11'd0 || int'(cap_len) > DEPTH) ? DEPTH : int'(cap_len);
      m_cnt   = 0;
      m_state = 1;
    end else if (in_valid && m_state == 1) begin
      hit = (m_mode == 0) || (m_prev < m_level && sx(in_x) >= m_level);
      if (hit) begin
        m_put(0);
        m_cnt   = 1;
        m_state = (m_len == 1) ? 3 : 2;
      end
    end else if (in_valid && m_state == 2) begin
      m_put(m_cnt);
      m_cnt++;
      if (m_cnt == m_len) m_state = 3;
    end
    if (in_valid) m_prev = sx(in_x);
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
    chk("busy", busy, (m_state == 1 || m_state == 2));
    chk("done", done, (m_state == 3));
    chk("wr_count", wr_count, m_cnt);
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data", rd_data, m_rd);
    arm = 1'b0; abort = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_arm(input bit mode, input int level, input int len);
    trig_mode = mode; trig_level = 16'(level); cap_len = 11'(len); arm = 1'b1;
    tick();
  endtask

  task automatic send(input int x, input int y, input int gap);
    in_valid = 1'b1; in_x = 16'(x); in_y = 16'(y);
    tick();
    repeat (gap) tick();
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = 10'(addr);
    tick();
    chk(tag, rd_data, exp);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cnt"}, wr_count, 32'd0);
    chk({tag, "_rv"}, rd_valid, 1'b0);
    chk({tag, "_rd"}, rd_data, 32'd0);
  endtask

  int          seq [5] = '{50, 99, 100, 150, 120};
  logic [15:0] y0;

  initial begin
    m_reset();
    #12;
    zero_chk("rst");
    @(posedge sys_clk); #1;
    rst_n = 1'b1;

    // Immediate capture of 4 pairs, one strobe every 8 cycles
    do_arm(1'b0, 0, 4);
    for (int i = 1; i <= 4; i++) send(i, -i, 7);
    chk("imm_done", done, 1'b1);
    chk("imm_cnt", wr_count, 32'd4);
    for (int i = 0; i < 4; i++) rd_chk("imm_rd", i, {16'(i + 1), 16'(-(i + 1))});

    // Rising threshold at 100
    do_arm(1'b1, 100, 3);
    for (int i = 0; i < 5; i++) send(seq[i], -seq[i], 1);
    chk("thr_done", done, 1'b1);
    chk("thr_cnt", wr_count, 32'd3);
    rd_chk("thr_rd0", 0, {16'd100, 16'hFF9C});
    rd_chk("thr_rd1", 1, {16'd150, 16'hFF6A});
    rd_chk("thr_rd2", 2, {16'd120, 16'hFF88});

    // Equal samples are not a rising crossing
    do_arm(1'b1, 100, 2);
    send(100, 0, 1);
    send(100, 0, 1);
    chk("norise_busy", busy, 1'b1);
    chk("norise_cnt", wr_count, 32'd0);
    send(50, 0, 1);
    send(101, 0, 1);
    send(7, 0, 1);
    chk("rise_done", done, 1'b1);
    rd_chk("rise_rd0", 0, {16'd101, 16'd0});

    // Negative threshold, signed compare
    do_arm(1'b1, -10, 1);
    send(-20, 3, 1);
    send(-10, 4, 1);
    chk("neg_done", done, 1'b1);
    chk("neg_cnt", wr_count, 32'd1);
    rd_chk("neg_rd0", 0, {16'hFFF6, 16'd4});
    do_arm(1'b1, -10, 1);
    send(5, 0, 1);
    send(-10, 0, 1);
    chk("negfall_busy", busy, 1'b1);
    chk("negfall_cnt", wr_count, 32'd0);
    abort = 1'b1; tick();

    // cap_len=0 fills the whole RAM and never wraps
    do_arm(1'b0, 0, 0);
    for (int i = 0; i < 1030; i++) begin
      logic [15:0] yv;
      yv = 16'($urandom);
      if (i == 0) y0 = yv;
      send(i + 3, int'(yv), 0);
    end
    chk("full_cnt", wr_count, 32'd1024);
    chk("full_done", done, 1'b1);
    rd_chk("full_rd0", 0, {16'd3, y0});

    // Abort mid-capture; arm during capture is ignored
    do_arm(1'b0, 0, 8);
    send(1, 1, 2);
    send(2, 2, 2);
    arm = 1'b1; tick();
    send(3, 3, 2);
    chk("ab_cnt_pre", wr_count, 32'd3);
    abort = 1'b1; tick();
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    chk("ab_cnt", wr_count, 32'd3);
    arm = 1'b1; abort = 1'b1; tick();
    chk("armab_busy", busy, 1'b0);
    chk("armab_cnt", wr_count, 32'd3);

    // Asynchronous reset in the middle of a capture
    do_arm(1'b0, 0, 8);
    send(4, 4, 1);
    send(5, 5, 1);
    rd_en = 1'b1; rd_addr = 10'd1; tick();
    rst_n = 1'b0;
    #2;
    zero_chk("mid_rst");
    m_reset();
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    do_arm(1'b0, 0, 2);
    send(9, 9, 1);
    send(10, 10, 1);
    chk("post_rst_done", done, 1'b1);
    chk("post_rst_cnt", wr_count, 32'd2);
    rd_chk("post_rst_rd1", 1, {16'd10, 16'd10});

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int a;
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        in_x = 16'($urandom_range(0, 40)) - 16'd20;
        in_y = 16'($urandom);
      end
      if ($urandom_range(0, 59) == 0) begin
        arm = 1'b1;
        trig_mode = 1'($urandom_range(0, 1));
        trig_level = 16'($urandom_range(0, 20)) - 16'd10;
        cap_len = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1025, 2047))
                                              : 11'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 149) == 0) abort = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        a = int'($urandom_range(0, DEPTH - 1));
        if (m_wr[a]) begin
          rd_en = 1'b1;
          rd_addr = 10'(a);
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
